// File: rtl/seg7_scan_driver.sv
// Multiplexed driver for an active-low, common-anode seven-segment display.
// Client data is double-buffered and committed only at frame boundaries.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    upd,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    CA,
  output logic                    CB,
  output logic                    CC,
  output logic                    CD,
  output logic                    CE,
  output logic                    CF,
  output logic                    CG,
  output logic                    DP,
  output logic                    frame_done
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // upd is a fire-and-forget strobe: there is no ready, every pulse is taken,
  // and a later pulse before the frame boundary replaces the earlier one.

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_pend_digits;
  logic [NUM_DIGITS-1:0]   r_pend_en;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [4*NUM_DIGITS-1:0] r_act_digits;
  logic [NUM_DIGITS-1:0]   r_act_en;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_done;

  logic                    w_cnt_wrap;
  logic                    w_boundary;
  logic                    w_lit;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [NUM_DIGITS-1:0]   w_an_next;
  logic [6:0]              w_seg_next;
  logic                    w_dp_next;

  // Segment pattern {a,b,c,d,e,f,g}, active-low.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'b0000001;
      4'h1: seg_decode = 7'b1001111;
      4'h2: seg_decode = 7'b0010010;
      4'h3: seg_decode = 7'b0000110;
      4'h4: seg_decode = 7'b1001100;
      4'h5: seg_decode = 7'b0100100;
      4'h6: seg_decode = 7'b0100000;
      4'h7: seg_decode = 7'b0001111;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0000100;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b1100000;
      4'hC: seg_decode = 7'b0110001;
      4'hD: seg_decode = 7'b1000010;
      4'hE: seg_decode = 7'b0110000;
      default: seg_decode = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    w_cnt_wrap = (r_cnt == CNT_W'(SCAN_DIV - 1));
    w_boundary = w_cnt_wrap && (r_idx == IDX_W'(NUM_DIGITS - 1));
    w_nib      = r_act_digits[{r_idx, 2'b00} +: 4];
    w_onehot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;
    // Leading cycles of each slot stay dark so the previous digit cannot ghost.
    w_lit      = (r_cnt >= CNT_W'(BLANK_CYC)) && r_act_en[r_idx];
    w_an_next  = '1;
    w_seg_next = '1;
    w_dp_next  = 1'b1;
    if (w_lit) begin
      w_an_next  = ~w_onehot;
      w_seg_next = seg_decode(w_nib);
      w_dp_next  = ~r_act_dp[r_idx];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_digits <= '0;
      r_pend_en     <= '0;
      r_pend_dp     <= '0;
      r_act_digits  <= '0;
      r_act_en      <= '0;
      r_act_dp      <= '0;
      r_an          <= '1;
      r_seg         <= '1;
      r_dp          <= 1'b1;
      r_frame_done  <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
      if (w_cnt_wrap) begin
        r_idx <= w_boundary ? '0 : r_idx + 1'b1;
      end
      r_frame_done <= w_boundary;
      // A strobe landing on the boundary cycle bypasses the pending buffer.
      if (w_boundary) begin
        r_pend_valid <= 1'b0;
        if (upd) begin
          r_act_digits <= digits_in;
          r_act_en     <= dig_en;
          r_act_dp     <= dp_in;
        end else if (r_pend_valid) begin
          r_act_digits <= r_pend_digits;
          r_act_en     <= r_pend_en;
          r_act_dp     <= r_pend_dp;
        end
      end else if (upd) begin
        r_pend_valid  <= 1'b1;
        r_pend_digits <= digits_in;
        r_pend_en     <= dig_en;
        r_pend_dp     <= dp_in;
      end
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
    end
  end

  assign AN                           = r_an;
  assign {CA, CB, CC, CD, CE, CF, CG} = r_seg;
  assign DP                           = r_dp;
  assign frame_done                   = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-position reference model feeding an
// expected-output queue, compared every cycle on the falling edge.
module tb_seg7_scan_driver;
  localparam int N     = 8;
  localparam int SD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = N * SD;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic          upd       = 1'b0;
  logic [31:0]   digits_in = '0;
  logic [7:0]    dig_en    = '0;
  logic [7:0]    dp_in     = '0;
  logic [7:0]    an;
  logic          ca, cb, cc, cd, ce, cf, cg, dp;
  logic          frame_done;

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .upd(upd),
    .digits_in(digits_in), .dig_en(dig_en), .dp_in(dp_in),
    .AN(an), .CA(ca), .CB(cb), .CC(cc), .CD(cd), .CE(ce), .CF(cf), .CG(cg),
    .DP(dp), .frame_done(frame_done)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // {frame_done, AN, a..g, DP}
  logic [16:0] exp_q[$];
  logic [6:0]  dec_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int n_checks = 0;
  int n_fail   = 0;

  // Model: position in frame and the contents shown in the current frame.
  int          m_pos;
  logic [31:0] m_dig, m_new_dig;
  logic [7:0]  m_en, m_dp, m_new_en, m_new_dp;
  bit          m_has_new;
  int          cyc;
  int          last_fd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_dig = '0; m_en = '0; m_dp = '0;
    m_new_dig = '0; m_new_en = '0; m_new_dp = '0;
    m_has_new = 1'b0;
    exp_q.delete();
    cyc = 0;
    last_fd = 0;
  endtask

  // Called right after a rising edge: outputs reflect the slot that just ended.
  task automatic model_edge(input logic u, input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
    int       di;
    int       ci;
    logic     lit;
    logic [7:0] x_an;
    logic [6:0] x_seg;
    logic       x_dp;
    di  = m_pos / SD;
    ci  = m_pos % SD;
    lit = (ci >= BC) && m_en[di];
    x_an  = 8'hFF;
    x_seg = 7'h7F;
    x_dp  = 1'b1;
    if (lit) begin
      x_an     = 8'hFF;
      x_an[di] = 1'b0;
      x_seg    = dec_tab[m_dig[di*4 +: 4]];
      x_dp     = ~m_dp[di];
    end
    exp_q.push_back({(m_pos == FRAME - 1), x_an, x_seg, x_dp});
    // The frame that starts shows the last strobe seen during the frame that ended.
    if (u) begin
      m_new_dig = d; m_new_en = e; m_new_dp = p; m_has_new = 1'b1;
    end
    if (m_pos == FRAME - 1) begin
      if (m_has_new) begin
        m_dig = m_new_dig; m_en = m_new_en; m_dp = m_new_dp;
      end
      m_has_new = 1'b0;
    end
    m_pos = (m_pos + 1) % FRAME;
  endtask

  task automatic check_outputs();
    logic [16:0] x;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      check_eq("frame_done", {31'd0, frame_done}, {31'd0, x[16]});
      check_eq("an", {24'd0, an}, {24'd0, x[15:8]});
      check_eq("seg", {25'd0, ca, cb, cc, cd, ce, cf, cg}, {25'd0, x[7:1]});
      check_eq("dp", {31'd0, dp}, {31'd0, x[0]});
    end
    check_eq("an_onehot", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // driver tasks
  task automatic step(input logic u, input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
    upd = u; digits_in = d; dig_en = e; dp_in = p;
    @(posedge sys_clk);
    model_edge(u, d, e, p);
    @(negedge sys_clk);
    cyc++;
    check_outputs();
    if (frame_done) begin
      check_eq("fd_period", cyc - last_fd, FRAME);
      last_fd = cyc;
    end
  endtask

  // Inputs wander while upd is low to show they are not captured.
  task automatic idle(input int n);
    repeat (n) step(1'b0, $urandom, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic post(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
    step(1'b1, d, e, p);
  endtask

  task automatic run_to_pos(input int target);
    while (m_pos != target) idle(1);
  endtask

  task automatic check_reset_state();
    check_eq("rst_an", {24'd0, an}, 32'h0000_00FF);
    check_eq("rst_seg", {25'd0, ca, cb, cc, cd, ce, cf, cg}, 32'h0000_007F);
    check_eq("rst_dp", {31'd0, dp}, 32'd1);
    check_eq("rst_fd", {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    model_reset();
    #2 sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check_reset_state();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();

    // Fresh data after reset waits for the first boundary.
    post(32'h8765_4321, 8'hFF, 8'h00);
    idle(2 * FRAME);

    // Mid-frame update must not tear the current frame.
    run_to_pos(10);
    post(32'hFEDC_BA98, 8'hFF, 8'h00);
    idle(FRAME + 5);

    // Reset while the display is lit.
    upd = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    check_reset_state();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
    idle(FRAME + 2);

    // Partial enable mask and a single decimal point.
    post(32'h0123_4567, 8'b1010_1010, 8'h02);
    idle(2 * FRAME);

    // Strobe exactly on the boundary cycle.
    run_to_pos(FRAME - 1);
    post(32'hA5A5_5A5A, 8'hFF, 8'hFF);
    idle(FRAME);

    // Two strobes in one frame: only the later is shown.
    run_to_pos(4);
    post(32'h1111_1111, 8'hFF, 8'h00);
    idle(6);
    post(32'hC0DE_9E7B, 8'h7E, 8'h81);
    idle(FRAME + 3);

    // Random traffic over several frames.
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ($urandom_range(0, 15) == 0)
        post($urandom, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      else
        idle(1);
    end
    idle(FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
